mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Memory-stage access controller between the EX/MEM and MEM/WB pipeline registers. It turns the load/store fields of the instruction in MEM into a req/ack transaction on the data-memory port. It holds the pipeline with `mem_stall` until the transaction completes, then presents the load data as `MEM_mem_result` to the MEM/WB register. A timeout guard keeps a dead memory from hanging the core.

## Interface
Parameters:
- `ADDR_W`, 22: data-memory address width; matches the PC width.
- `TIMEOUT_CYCLES`, 255: maximum number of WAIT cycles without `mem_ack`.
- `CNT_W`, 8: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- `clk`, in, 1: the only clock.
- `rst`, in, 1: synchronous reset, active-high.
- `flush`, in, 1: pipeline flush; the instruction in MEM is squashed.
- `hlt`, in, 1: core halted; no new access is issued.
- `MEM_mem_read`, in, 1: instruction in MEM is a load.
- `MEM_mem_write`, in, 1: instruction in MEM is a store. Read and write both high is treated as a read.
- `MEM_ALU_result`, in, 32: effective address. Bits [ADDR_W-1:0] are used; upper bits are ignored.
- `MEM_store_data`, in, 32: store data.
- `mem_req`, out, 1: memory request. Held high until acked.
- `mem_we`, out, 1: write enable, valid while `mem_req` is high.
- `mem_addr`, out, ADDR_W: address, stable while `mem_req` is high.
- `mem_wdata`, out, 32: write data, stable while `mem_req` is high.
- `mem_ack`, in, 1: one-cycle completion strobe.
- `mem_rdata`, in, 32: read data, valid in the `mem_ack` cycle.
- `MEM_mem_result`, out, 32: load result feeding the MEM/WB register.
- `mem_stall`, out, 1: stalls all pipeline registers.
- `bus_err`, out, 1: sticky timeout flag.

## Operation
- States, in a shared enum: IDLE, WAIT, DONE, DRAIN.
- IDLE:
  - An access is `(MEM_mem_read | MEM_mem_write) & !flush & !hlt`.
  - When an access is present: latch address, write data and `we`; go to WAIT.
  - `mem_stall` = access present, combinational.
  - With no access present: `mem_stall` = 0 and the state stays IDLE.
- WAIT:
  - `mem_req` = 1; `mem_stall` = 1; the timeout counter increments each cycle.
  - On `mem_ack`: capture `mem_rdata` into the result register (loads only; stores leave it unchanged); go to DONE.
  - If `flush` was seen in WAIT (recorded in `flushed_q`) the next state is DRAIN behaviour instead: IDLE, with no result update.
  - If the counter reaches TIMEOUT_CYCLES without `mem_ack`: drop `mem_req`, set `bus_err`, force the result to 0, go to DONE.
- DONE:
  - `mem_stall` = 0 and `MEM_mem_result` is valid. The pipeline advances at the end of this cycle.
  - Next state is IDLE, unconditionally, so the same instruction is never reissued.
- DRAIN:
  - Entered when `flush` arrives in WAIT and the access is still outstanding. An issued bus transaction is never aborted.
  - Keep `mem_req` high and `mem_stall` high until `mem_ack`, then go to IDLE and discard the data.
  - A timeout in DRAIN sets `bus_err` and goes to IDLE.
- `MEM_mem_result` is a register. It holds its value between accesses.
- `hlt` blocks issue only from IDLE. An outstanding access always completes.

## Timing
- Reset values:
  - state = IDLE
  - `mem_req` = 0, `mem_we` = 0
  - `mem_addr` = 0, `mem_wdata` = 0
  - `MEM_mem_result` = 0
  - `bus_err` = 0
  - counter = 0, `flushed_q` = 0
- `mem_req`, `mem_we`, `mem_addr` and `mem_wdata` are registered. `mem_req` rises in the cycle after the access is seen in IDLE.
- Latency, with `mem_ack` in cycle n:
  - Access seen in cycle 0; `mem_req` is high from cycle 1.
  - Stall is high in cycles 0..n.
  - DONE is cycle n+1, with the result valid and stall low.
  - Minimum total is 2 stall cycles (ack in cycle 1).
- `mem_req` falls in the cycle after `mem_ack`.
- `mem_ack` seen outside WAIT/DRAIN is ignored.
- The counter clears on entry to WAIT.
- Timeout fires when counter == TIMEOUT_CYCLES - 1 and `mem_ack` = 0 in that cycle. An ack in that same cycle wins.
- `rst` asserted mid-transaction returns everything to reset values next cycle, including `mem_req` = 0. The memory side is reset together with the core.
- `flush` in DONE has no effect on this block; the MEM/WB register squashes the result.

## Structure
- Package `mem_pkg`: state enum `mem_state_t`, the bad-result constant (32'h0), and the default timeout.
- Sub-module `timeout_ctr`: loadable up-counter with clear, enable, and terminal-count output, parameterised by CNT_W. It is the only sub-module.
- Expected size: 150-250 lines of RTL.

## Test plan
- Load, ack in cycle 3, rdata = 32'hCAFE_0001:
  - Stall is high in cycles 0-3.
  - `MEM_mem_result` = 32'hCAFE_0001 in cycle 4, with stall low.
  - `mem_addr` equals `MEM_ALU_result[21:0]`.
- Store, ack in cycle 1:
  - `mem_we` = 1 with `mem_wdata` = `MEM_store_data` in cycle 1.
  - Stall is high in cycles 0-1.
  - `MEM_mem_result` is unchanged from the previous value.
- Back-to-back loads (the next load is presented in the cycle after DONE): two distinct transactions, each with one `mem_req` pulse train; no duplicate request.
- Flush in cycle 2 of a load with ack in cycle 5:
  - `mem_req` stays high until cycle 5; stall stays high through cycle 5.
  - Result is not updated; the state is IDLE in cycle 6.
- TIMEOUT_CYCLES = 4 and `mem_ack` never asserted:
  - `mem_req` drops after 4 WAIT cycles.
  - `bus_err` = 1 and stays set; result = 0; stall releases in DONE.
- `rst` pulsed during WAIT, and `hlt` = 1 with a load presented:
  - After reset, all outputs are at their reset values.
  - With `hlt` = 1, no `mem_req` is issued and stall stays 0.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and constants for the memory-stage access controller.
package mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DONE,
    ST_DRAIN
  } mem_state_t;

  localparam logic [31:0] BAD_RESULT      = 32'h0;
  localparam int          DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/timeout_ctr.sv
// Loadable up-counter with clear and enable; o_tc flags r_cnt == i_tc_val.
module timeout_ctr #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_en,
  input  logic [CNT_W-1:0] i_tc_val,
  output logic             o_tc
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_tc = (r_cnt == i_tc_val);

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage req/ack access controller: stalls the pipeline until the data
// memory acks, presents load data, and bounds every wait with a timeout.
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | no access outstanding; issue when a load/store is in MEM
// WAIT     | request on the bus, pipeline stalled
// DONE     | result valid, stall released for one cycle
// DRAIN    | flushed while outstanding; finish the bus cycle, drop data
import mem_pkg::*;

module mem_access_unit #(
  parameter int ADDR_W         = 22,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT,
  parameter int CNT_W          = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              hlt,
  input  logic              MEM_mem_read,
  input  logic              MEM_mem_write,
  input  logic [31:0]       MEM_ALU_result,
  input  logic [31:0]       MEM_store_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic [31:0]       MEM_mem_result,
  output logic              mem_stall,
  output logic              bus_err
);

  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TIMEOUT_CYCLES - 1);

  mem_state_t        r_state;
  logic              r_req;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_result;
  logic              r_bus_err;
  logic              r_flushed;

  logic w_access;
  logic w_issue;
  logic w_busy;
  logic w_squash;
  logic w_tc;
  logic [31-ADDR_W:0] w_unused_addr_hi;

  assign w_unused_addr_hi = MEM_ALU_result[31:ADDR_W];

  always_comb begin
    w_access  = (MEM_mem_read | MEM_mem_write) & ~flush & ~hlt;
    w_issue   = (r_state == ST_IDLE) & w_access;
    w_busy    = (r_state == ST_WAIT) | (r_state == ST_DRAIN);
    w_squash  = flush | r_flushed;
    mem_stall = w_issue | w_busy;
  end

  timeout_ctr #(.CNT_W(CNT_W)) u_timeout_ctr (
    .clk        (clk),
    .rst        (rst),
    .i_clr      (w_issue),
    .i_load     (1'b0),
    .i_load_val ('0),
    .i_en       (w_busy),
    .i_tc_val   (TC_VAL),
    .o_tc       (w_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_req     <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_result  <= '0;
      r_bus_err <= 1'b0;
      r_flushed <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_access) begin
            r_addr  <= MEM_ALU_result[ADDR_W-1:0];
            r_wdata <= MEM_store_data;
            r_we    <= ~MEM_mem_read;
            r_req   <= 1'b1;
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT, ST_DRAIN: begin
          // A squashed access still completes on the bus; only its result is dropped.
          if (mem_ack) begin
            r_req     <= 1'b0;
            r_we      <= 1'b0;
            r_flushed <= 1'b0;
            if (w_squash) begin
              r_state <= ST_IDLE;
            end else begin
              if (!r_we) r_result <= mem_rdata;
              r_state <= ST_DONE;
            end
          end else if (w_tc) begin
            r_req     <= 1'b0;
            r_we      <= 1'b0;
            r_flushed <= 1'b0;
            r_bus_err <= 1'b1;
            if (w_squash) begin
              r_state <= ST_IDLE;
            end else begin
              r_result <= BAD_RESULT;
              r_state  <= ST_DONE;
            end
          end else if (flush) begin
            r_flushed <= 1'b1;
            r_state   <= ST_DRAIN;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign mem_req        = r_req;
  assign mem_we         = r_we;
  assign mem_addr       = r_addr;
  assign mem_wdata      = r_wdata;
  assign MEM_mem_result = r_result;
  assign bus_err        = r_bus_err;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: a long-timeout instance for the main
// flows and a TIMEOUT_CYCLES=4 instance sharing the same stimulus.
module tb_mem_access_unit;

  localparam int ADDR_W = 22;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        hlt;
  logic        MEM_mem_read;
  logic        MEM_mem_write;
  logic [31:0] MEM_ALU_result;
  logic [31:0] MEM_store_data;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  logic              mem_req,    mem_req_to;
  logic              mem_we,     mem_we_to;
  logic [ADDR_W-1:0] mem_addr,   mem_addr_to;
  logic [31:0]       mem_wdata,  mem_wdata_to;
  logic [31:0]       MEM_mem_result, result_to;
  logic              mem_stall,  stall_to;
  logic              bus_err,    bus_err_to;

  int n_checks = 0;
  int n_errors = 0;
  int req_rises = 0;
  logic prev_stall = 1'b0;
  logic prev_req = 1'b0;
  logic [31:0] model_result = 32'h0;
  logic [31:0] exp_q[$];

  mem_access_unit #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(16), .CNT_W(5)) u_dut (
    .clk(clk), .rst(rst), .flush(flush), .hlt(hlt),
    .MEM_mem_read(MEM_mem_read), .MEM_mem_write(MEM_mem_write),
    .MEM_ALU_result(MEM_ALU_result), .MEM_store_data(MEM_store_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .MEM_mem_result(MEM_mem_result), .mem_stall(mem_stall), .bus_err(bus_err)
  );

  mem_access_unit #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(4), .CNT_W(3)) u_dut_to (
    .clk(clk), .rst(rst), .flush(flush), .hlt(hlt),
    .MEM_mem_read(MEM_mem_read), .MEM_mem_write(MEM_mem_write),
    .MEM_ALU_result(MEM_ALU_result), .MEM_store_data(MEM_store_data),
    .mem_req(mem_req_to), .mem_we(mem_we_to), .mem_addr(mem_addr_to), .mem_wdata(mem_wdata_to),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .MEM_mem_result(result_to), .mem_stall(stall_to), .bus_err(bus_err_to)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  // Every stall high->low transition is a point where the MEM/WB register takes a result.
  always @(negedge clk) begin
    if (prev_stall && !mem_stall) begin
      if (exp_q.size() != 0) chk("result", MEM_mem_result, exp_q.pop_front());
      else chk("spurious_done", 32'(exp_q.size()), 32'd1);
    end
    if (mem_req && !prev_req) req_rises++;
    prev_stall = mem_stall;
    prev_req   = mem_req;
  end

  task automatic check_reset(input string tag);
    chk({tag, "_req"},     mem_req,        0);
    chk({tag, "_we"},      mem_we,         0);
    chk({tag, "_addr"},    mem_addr,       0);
    chk({tag, "_wdata"},   mem_wdata,      0);
    chk({tag, "_result"},  MEM_mem_result, 0);
    chk({tag, "_bus_err"}, bus_err,        0);
    chk({tag, "_stall"},   mem_stall,      0);
    chk({tag, "_err_to"},  bus_err_to,     0);
  endtask

  // Called at posedge+1; returns at posedge+1 of the cycle after DONE/IDLE return.
  task automatic run_access(input logic rd, input logic wr, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] rdata,
                            input int ack_cyc, input int flush_cyc);
    logic [31:0] a;
    a = addr;
    MEM_mem_read = rd; MEM_mem_write = wr;
    MEM_ALU_result = addr; MEM_store_data = wdata;
    if (rd && flush_cyc < 0) model_result = rdata;
    exp_q.push_back(model_result);
    for (int c = 0; c <= ack_cyc + 1; c++) begin
      mem_ack   = (c == ack_cyc);
      mem_rdata = (c == ack_cyc) ? rdata : 32'hDEAD_BEEF;
      flush     = (c == flush_cyc);
      @(negedge clk);
      chk("stall", mem_stall, (c <= ack_cyc) ? 32'd1 : 32'd0);
      if (c >= 1 && c <= ack_cyc) begin
        chk("req", mem_req, 1);
        chk("we", mem_we, {31'b0, wr & ~rd});
        chk("addr", mem_addr, a[ADDR_W-1:0]);
        if (wr && !rd) chk("wdata", mem_wdata, wdata);
      end else begin
        chk("req_idle", mem_req, 0);
      end
      @(posedge clk); #1;
      if (c == flush_cyc) begin MEM_mem_read = 0; MEM_mem_write = 0; end
    end
    mem_ack = 0; flush = 0; MEM_mem_read = 0; MEM_mem_write = 0;
  endtask

  task automatic do_reset(input string tag);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    model_result = 32'h0;
    @(negedge clk);
    check_reset(tag);
    @(posedge clk); #1;
  endtask

  initial begin
    int rises0;
    rst = 1; flush = 0; hlt = 0; MEM_mem_read = 0; MEM_mem_write = 0;
    MEM_ALU_result = 0; MEM_store_data = 0; mem_ack = 0; mem_rdata = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset("por");
    @(posedge clk); #1;
    rst = 0;

    run_access(1, 0, 32'hFFC1_2344, 32'h0, 32'hCAFE_0001, 3, -1);
    run_access(0, 1, 32'h0000_0ABC, 32'h1234_5678, 32'h0BAD_0BAD, 1, -1);

    rises0 = req_rises;
    run_access(1, 0, 32'h0000_1000, 32'h0, 32'hAAAA_0001, 2, -1);
    run_access(1, 0, 32'h0000_1004, 32'h0, 32'hBBBB_0002, 1, -1);
    chk("b2b_req_pulses", 32'(req_rises - rises0), 2);

    run_access(1, 1, 32'h0030_0010, 32'h5555_5555, 32'h7777_0003, 2, -1);

    // Ack in the last allowed cycle of the short-timeout instance beats the timeout.
    run_access(1, 0, 32'h0000_2000, 32'h0, 32'h1357_9BDF, 4, -1);
    chk("to_ack_wins_result", result_to, 32'h1357_9BDF);
    chk("to_ack_wins_err", bus_err_to, 0);

    run_access(1, 0, 32'h0000_3000, 32'h0, 32'hFEED_FACE, 5, 2);
    chk("to_drain_timeout_err", bus_err_to, 1);
    chk("to_drain_result", result_to, 32'h1357_9BDF);

    do_reset("rst_idle");

    run_access(1, 0, 32'h0000_4000, 32'h0, 32'h2468_ACE0, 2, -1);
    chk("to_pre_timeout_result", result_to, 32'h2468_ACE0);

    // No ack for the short-timeout instance; the main instance gets its ack in cycle 7.
    MEM_mem_read = 1; MEM_ALU_result = 32'h0000_5000;
    model_result = 32'h0F0F_0F0F;
    exp_q.push_back(model_result);
    for (int c = 0; c <= 8; c++) begin
      mem_ack   = (c == 7);
      mem_rdata = (c == 7) ? 32'h0F0F_0F0F : 32'hDEAD_BEEF;
      @(negedge clk);
      chk("to_req", mem_req_to, (c >= 1 && c <= 4) ? 32'd1 : 32'd0);
      if (c <= 6) chk("to_stall", stall_to, (c <= 4) ? 32'd1 : 32'd0);
      if (c == 5) begin
        chk("to_bus_err", bus_err_to, 1);
        chk("to_result_bad", result_to, 0);
      end
      if (c == 8) chk("to_bus_err_sticky", bus_err_to, 1);
      chk("main_req", mem_req, (c >= 1 && c <= 7) ? 32'd1 : 32'd0);
      @(posedge clk); #1;
      if (c == 5) MEM_mem_read = 0;
    end
    mem_ack = 0;

    // Reset while the main instance waits on the bus.
    MEM_mem_read = 1; MEM_ALU_result = 32'h0000_6000;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("pre_rst_req", mem_req, 1);
    @(posedge clk); #1;
    model_result = 32'h0;
    exp_q.push_back(model_result);
    rst = 1; MEM_mem_read = 0;
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    check_reset("rst_wait");
    @(posedge clk); #1;

    hlt = 1; MEM_mem_read = 1; MEM_ALU_result = 32'h0000_7000;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("hlt_stall", mem_stall, 0);
      chk("hlt_req", mem_req, 0);
      @(posedge clk); #1;
    end
    hlt = 0; MEM_mem_read = 0;
    @(negedge clk);
    chk("post_hlt_req", mem_req, 0);

    chk("queue_drained", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
